// File: rtl/full_adder_bit_pkg.sv
// Shared arithmetic constants and result type for the adder-chain primitives.
// Widths stay at one bit here; chain wrappers replicate the cell.
package full_adder_bit_pkg;
   localparam int ADD_W = 1;

   typedef struct packed {
      logic carry;
      logic sum;
   } add_res_t;
endpackage

// File: rtl/full_adder_bit_if.sv
// Operand/result bundle for one full-adder cell; the adder owns the slave side.
// Combinational results plus their registered copies travel together.
interface full_adder_bit_if;
   logic in1;
   logic in2;
   logic cin;
   logic sum;
   logic carry;
   logic sum_q;
   logic carry_q;

   modport master (
      output in1, in2, cin,
      input  sum, carry, sum_q, carry_q
   );

   modport slave (
      input  in1, in2, cin,
      output sum, carry, sum_q, carry_q
   );
endinterface

// File: rtl/full_adder_bit_half_adder.sv
// Half adder: s = a ^ b, c = a & b; purely combinational, zero latency.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/full_adder_bit.sv
// One-bit full adder: combinational sum/carry (0 cycles) plus registered copies (1 cycle).
// No flow control; the registered copies clear on synchronous active-low reset.
module full_adder_bit
   import full_adder_bit_pkg::*;
(
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   full_adder_bit_if.slave  bus
);
   logic     w_s1;
   logic     w_c1;
   logic     w_c2;
   logic     w_sum;
   add_res_t w_res;
   logic     r_sum_q;
   logic     r_carry_q;

   half_adder u_ha1 (.a(bus.in1), .b(bus.in2), .s(w_s1),  .c(w_c1));
   half_adder u_ha2 (.a(w_s1),    .b(bus.cin), .s(w_sum), .c(w_c2));

   // Combinational path must not see reset so the cell can sit in a ripple chain.
   assign w_res = '{carry: (w_c1 | w_c2), sum: w_sum};

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_sum_q   <= 1'b0;
         r_carry_q <= 1'b0;
      end else begin
         r_sum_q   <= w_res.sum;
         r_carry_q <= w_res.carry;
      end
   end

   assign bus.sum     = w_res.sum;
   assign bus.carry   = w_res.carry;
   assign bus.sum_q   = r_sum_q;
   assign bus.carry_q = r_carry_q;
endmodule

// File: tb/tb_full_adder_bit.sv
// Self-checking bench for full_adder_bit: directed, random and two-cell ripple checks.
module tb_full_adder_bit;
   logic sys_clk;
   logic sys_rst_n;
   int   checks;
   int   errors;

   full_adder_bit_if dut_if ();
   full_adder_bit_if c0_if ();
   full_adder_bit_if c1_if ();

   full_adder_bit u_dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(dut_if.slave));
   full_adder_bit u_c0  (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(c0_if.slave));
   full_adder_bit u_c1  (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(c1_if.slave));

   assign c1_if.cin = c0_if.carry;

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] ref_add(input logic a, input logic b, input logic c);
      int total;
      total = int'(a) + int'(b) + int'(c);
      return total[1:0];
   endfunction

   task automatic drive(input logic [2:0] v);
      dut_if.in1 = v[2];
      dut_if.in2 = v[1];
      dut_if.cin = v[0];
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      logic [1:0] table_exp [8];
      logic [1:0] exp_q;
      logic [2:0] v;
      logic [1:0] a;
      logic [1:0] b;
      logic       ci;
      int         total;

      checks = 0;
      errors = 0;
      table_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
      sys_rst_n = 1'b0;
      drive(3'b000);
      c0_if.in1 = 1'b0; c0_if.in2 = 1'b0; c0_if.cin = 1'b0;
      c1_if.in1 = 1'b0; c1_if.in2 = 1'b0;

      @(posedge sys_clk); #1;
      check_val("reset_q", {dut_if.carry_q, dut_if.sum_q}, 4'd0);

      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         drive(v);
         #1;
         check_val($sformatf("exh_%0d", i), {dut_if.carry, dut_if.sum}, table_exp[i]);
      end

      // Hold reset over three edges with 111 applied.
      @(negedge sys_clk);
      drive(3'b111);
      for (int i = 0; i < 3; i++) begin
         @(posedge sys_clk); #1;
         check_val($sformatf("rst_q_%0d", i), {dut_if.carry_q, dut_if.sum_q}, 4'd0);
         check_val($sformatf("rst_comb_%0d", i), {dut_if.carry, dut_if.sum}, 4'd3);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(posedge sys_clk); #1;
      check_val("rst_release_q", {dut_if.carry_q, dut_if.sum_q}, 4'd3);

      // Latency: 011 then 000.
      @(negedge sys_clk);
      drive(3'b011);
      @(posedge sys_clk); #1;
      check_val("lat_edge_n", {dut_if.carry_q, dut_if.sum_q}, 4'd2);
      @(negedge sys_clk);
      drive(3'b000);
      @(posedge sys_clk); #1;
      check_val("lat_edge_n1", {dut_if.carry_q, dut_if.sum_q}, 4'd0);

      // Mid-stream reset with 101 applied.
      @(negedge sys_clk);
      drive(3'b101);
      @(posedge sys_clk); #1;
      check_val("mid_pre_q", {dut_if.carry_q, dut_if.sum_q}, 4'd2);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      check_val("mid_rst_q", {dut_if.carry_q, dut_if.sum_q}, 4'd0);
      check_val("mid_rst_comb", {dut_if.carry, dut_if.sum}, 4'd2);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // Random: mid-cycle input glitch, occasional reset, registered copy checked per edge.
      for (int i = 0; i < 220; i++) begin
         @(negedge sys_clk);
         sys_rst_n = ($urandom_range(0, 9) != 0);
         v = 3'($urandom_range(0, 7));
         drive(v);
         #1;
         check_val("rnd_comb_a", {dut_if.carry, dut_if.sum}, ref_add(v[2], v[1], v[0]));
         #1;
         v = 3'($urandom_range(0, 7));
         drive(v);
         #1;
         check_val("rnd_comb_b", {dut_if.carry, dut_if.sum}, ref_add(v[2], v[1], v[0]));
         exp_q = sys_rst_n ? ref_add(v[2], v[1], v[0]) : 2'd0;
         @(posedge sys_clk); #1;
         check_val("rnd_q", {dut_if.carry_q, dut_if.sum_q}, exp_q);
      end
      sys_rst_n = 1'b1;

      // Ripple chain: A=11, B=01, cin=0 -> 3 + 1 = 4.
      c0_if.in1 = 1'b1; c1_if.in1 = 1'b1;
      c0_if.in2 = 1'b1; c1_if.in2 = 1'b0;
      c0_if.cin = 1'b0;
      #1;
      check_val("chain_3p1", {c1_if.carry, c1_if.sum, c0_if.sum}, 4'd4);

      for (int i = 0; i < 32; i++) begin
         a  = 2'($urandom_range(0, 3));
         b  = 2'($urandom_range(0, 3));
         ci = 1'($urandom_range(0, 1));
         c0_if.in1 = a[0]; c1_if.in1 = a[1];
         c0_if.in2 = b[0]; c1_if.in2 = b[1];
         c0_if.cin = ci;
         #1;
         total = int'(a) + int'(b) + int'(ci);
         check_val("chain_rnd", {c1_if.carry, c1_if.sum, c0_if.sum}, 4'(total));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
